// File: rtl/key_arb_pkg.sv
// Shared types and default sizing for the key-sequence round-robin arbiter.
package key_arb_pkg;

   localparam int unsigned NumReqDef  = 4;
   localparam int unsigned KeyWDef    = 4;
   localparam int unsigned ErrCntWDef = 8;

   typedef logic [$clog2(NumReqDef)-1:0] id_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StAck
   } arb_state_t;

endpackage

// File: rtl/key_arbiter_if.sv
// Requester, downstream-service and error-report signals of key_arbiter.
interface key_arbiter_if
   import key_arb_pkg::*;
#(
   parameter int unsigned NumReq  = NumReqDef,
   parameter int unsigned KeyW    = KeyWDef,
   parameter int unsigned ErrCntW = ErrCntWDef
) ();

   localparam int unsigned IdW = $clog2(NumReq);

   logic [NumReq-1:0]      req;
   logic [NumReq*KeyW-1:0] req_key;
   logic [NumReq-1:0]      ack;
   logic                   srv_valid;
   logic [KeyW-1:0]        srv_key;
   logic [IdW-1:0]         srv_id;
   logic                   srv_ready;
   logic                   err_valid;
   logic [IdW-1:0]         err_id;
   logic [ErrCntW-1:0]     err_count;

   // Requesters plus downstream consumer.
   modport master (
      output req, req_key, srv_ready,
      input  ack, srv_valid, srv_key, srv_id, err_valid, err_id, err_count
   );

   // The arbiter itself.
   modport slave (
      input  req, req_key, srv_ready,
      output ack, srv_valid, srv_key, srv_id, err_valid, err_id, err_count
   );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr_i, wrapping.
module rr_pick
   import key_arb_pkg::*;
#(
   parameter int unsigned NumReq = NumReqDef,
   localparam int unsigned IdW   = $clog2(NumReq)
) (
   input  logic [NumReq-1:0] req_i,
   input  logic [IdW-1:0]    ptr_i,
   output logic [IdW-1:0]    winner_o,
   output logic              any_req_o
);

   logic [IdW-1:0] idx;
   logic           found;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         idx = IdW'((32'(ptr_i) + i) % NumReq);
         if (!found && req_i[idx]) begin
            found    = 1'b1;
            winner_o = idx;
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/key_arbiter.sv
// Round-robin arbiter sharing one key-service port; checks each requester's +1 key sequence.
module key_arbiter
   import key_arb_pkg::*;
#(
   parameter int unsigned NumReq  = NumReqDef,
   parameter int unsigned KeyW    = KeyWDef,
   parameter int unsigned ErrCntW = ErrCntWDef
) (
   input logic          clk,
   input logic          rst_n,
   key_arbiter_if.slave bus_io
);

   localparam int unsigned IdW = $clog2(NumReq);

   arb_state_t         state_q, state_d;
   logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IdW-1:0]     srv_id_q, srv_id_d;
   logic [IdW-1:0]     err_id_q, err_id_d;
   logic [IdW-1:0]     winner;
   logic               any_req;
   logic [KeyW-1:0]    win_key;
   logic [KeyW-1:0]    srv_key_q, srv_key_d;
   logic [KeyW-1:0]    exp_q [NumReq];
   logic [KeyW-1:0]    exp_d [NumReq];
   logic               srv_valid_q, srv_valid_d;
   logic               err_valid_q, err_valid_d;
   logic [NumReq-1:0]  ack_q, ack_d;
   logic [ErrCntW-1:0] err_count_q, err_count_d;

   rr_pick #(
      .NumReq (NumReq)
   ) u_rr_pick (
      .req_i     (bus_io.req),
      .ptr_i     (rr_ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   assign win_key = bus_io.req_key[winner*KeyW +: KeyW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (any_req) state_d = StIssue;
         StIssue: if (srv_valid_q && bus_io.srv_ready) state_d = StAck;
         StAck:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Inputs are deliberately not looked at in StAck: keys may follow ack combinationally.
   always_comb begin
      srv_valid_d = srv_valid_q;
      srv_key_d   = srv_key_q;
      srv_id_d    = srv_id_q;
      ack_d       = '0;
      err_valid_d = 1'b0;
      err_id_d    = err_id_q;
      err_count_d = err_count_q;
      rr_ptr_d    = rr_ptr_q;
      exp_d       = exp_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               srv_valid_d = 1'b1;
               srv_id_d    = winner;
               srv_key_d   = win_key;
               if (win_key != exp_q[winner]) begin
                  err_valid_d = 1'b1;
                  err_id_d    = winner;
                  if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
               end
            end
         end
         StIssue: begin
            if (srv_valid_q && bus_io.srv_ready) begin
               srv_valid_d      = 1'b0;
               ack_d[srv_id_q]  = 1'b1;
            end
         end
         StAck: begin
            exp_d[srv_id_q] = srv_key_q + 1'b1;
            rr_ptr_d = (srv_id_q == IdW'(NumReq - 1)) ? '0 : srv_id_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         srv_valid_q <= 1'b0;
         srv_key_q   <= '0;
         srv_id_q    <= '0;
         ack_q       <= '0;
         err_valid_q <= 1'b0;
         err_id_q    <= '0;
         err_count_q <= '0;
         rr_ptr_q    <= '0;
         for (int unsigned i = 0; i < NumReq; i++) exp_q[i] <= '0;
      end else begin
         srv_valid_q <= srv_valid_d;
         srv_key_q   <= srv_key_d;
         srv_id_q    <= srv_id_d;
         ack_q       <= ack_d;
         err_valid_q <= err_valid_d;
         err_id_q    <= err_id_d;
         err_count_q <= err_count_d;
         rr_ptr_q    <= rr_ptr_d;
         exp_q       <= exp_d;
      end
   end

   assign bus_io.srv_valid = srv_valid_q;
   assign bus_io.srv_key   = srv_key_q;
   assign bus_io.srv_id    = srv_id_q;
   assign bus_io.ack       = ack_q;
   assign bus_io.err_valid = err_valid_q;
   assign bus_io.err_id    = err_id_q;
   assign bus_io.err_count = err_count_q;

endmodule
